// File: rtl/mov_reg_unit_if.sv
// mov_reg_unit_if: operation handshake and read-port bundle for mov_reg_unit.
//   master: op_valid/op_code/dst/src/imm/imm_sext/rd_addr out; op_ready/rd_data/done/err in
//   slave : the reverse direction (the register-move unit itself)
interface mov_reg_unit_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IMM_W = 4
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             op_valid;
  logic             op_ready;
  logic [1:0]       op_code;
  logic [AW-1:0]    dst;
  logic [AW-1:0]    src;
  logic [IMM_W-1:0] imm;
  logic             imm_sext;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             done;
  logic             err;

  modport master (
    output op_valid, op_code, dst, src, imm, imm_sext, rd_addr,
    input  op_ready, rd_data, done, err
  );

  modport slave (
    input  op_valid, op_code, dst, src, imm, imm_sext, rd_addr,
    output op_ready, rd_data, done, err
  );
endinterface

// File: rtl/mov_reg_unit.sv
// mov_reg_unit: WIDTH x DEPTH register bank with a move engine (MOV, MOVI, CLR, SWAP)
// behind a valid/ready handshake, one write port, registered done/err pulses and a
// combinational read port.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : mov_reg_unit_if.slave (op handshake, operands, read port, done/err)
// Build option: define MOV_SWAP_EN to implement SWAP as a two-cycle operation;
// without it op_code 11 is accepted as a NOP that flags err.
module mov_reg_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IMM_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mov_reg_unit_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] imm_ext;

`ifdef MOV_SWAP_EN
  typedef enum logic {
    IDLE  = 1'b0,
    SWAP2 = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;
  // Swap source is only sampled at accept, so it is held for the second write.
  logic [AW-1:0]    swap_src_q, swap_src_d;

  assign bus.op_ready = (state_q == IDLE);
`else
  assign bus.op_ready = 1'b1;
`endif

  assign accept      = bus.op_valid && bus.op_ready;
  assign imm_ext     = bus.imm_sext ? WIDTH'($signed(bus.imm)) : WIDTH'(bus.imm);
  assign bus.rd_data = regs_q[bus.rd_addr];
  assign bus.done    = done_q;
  assign bus.err     = err_q;

  // Operation decode: selects the single write and the completion flags.
  always_comb begin : op_decode
    wr_en   = 1'b0;
    wr_addr = bus.dst;
    wr_data = regs_q[bus.src];
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef MOV_SWAP_EN
    state_d    = state_q;
    tmp_d      = tmp_q;
    swap_src_d = swap_src_q;

    if (state_q == SWAP2) begin
      // Second half of a swap: old R[dst] lands in R[src].
      wr_en   = 1'b1;
      wr_addr = swap_src_q;
      wr_data = tmp_q;
      done_d  = 1'b1;
      state_d = IDLE;
    end else
`endif
    if (accept) begin
      done_d = 1'b1;
      case (bus.op_code)
        OP_MOV: begin
          wr_en   = 1'b1;
          wr_data = regs_q[bus.src];
        end
        OP_MOVI: begin
          wr_en   = 1'b1;
          wr_data = imm_ext;
        end
        OP_CLR: begin
          wr_en   = 1'b1;
          wr_data = '0;
        end
        OP_SWAP: begin
`ifdef MOV_SWAP_EN
          wr_en      = 1'b1;
          wr_data    = regs_q[bus.src];
          tmp_d      = regs_q[bus.dst];
          swap_src_d = bus.src;
          state_d    = SWAP2;
          done_d     = 1'b0;
`else
          err_d = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // Single write port into the bank.
  always_comb begin : bank_next
    for (int i = 0; i < int'(DEPTH); i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_regs
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef MOV_SWAP_EN
      state_q    <= IDLE;
      tmp_q      <= '0;
      swap_src_q <= '0;
`endif
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= regs_d[i];
      end
      done_q <= done_d;
      err_q  <= err_d;
`ifdef MOV_SWAP_EN
      state_q    <= state_d;
      tmp_q      <= tmp_d;
      swap_src_q <= swap_src_d;
`endif
    end
  end

endmodule

// File: tb/tb_mov_reg_unit.sv
// tb_mov_reg_unit: directed scenarios plus randomized operations checked against a
// behavioural register-file model; all checks go through check_val.
module tb_mov_reg_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IMM_W = 4;
  localparam int unsigned AW    = 2;

  localparam int OP_MOV  = 0;
  localparam int OP_MOVI = 1;
  localparam int OP_CLR  = 2;
  localparam int OP_SWAP = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #10 clk = ~clk;

  mov_reg_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IMM_W(IMM_W)) bus ();

  mov_reg_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IMM_W(IMM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the bank as plain integers plus a pending swap completion.
  int unsigned m_r [DEPTH];
  bit          m_busy;
  int unsigned m_psrc;
  int unsigned m_pval;
  bit          m_done;
  bit          m_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ext_imm(input int unsigned imm, input bit sext);
    int unsigned v;
    v = imm % (1 << IMM_W);
    if (sext && v >= (1 << (IMM_W - 1)))
      return (v + (1 << WIDTH) - (1 << IMM_W)) % (1 << WIDTH);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) m_r[i] = 0;
    m_busy = 0;
    m_psrc = 0;
    m_pval = 0;
    m_done = 0;
    m_err  = 0;
  endtask

  // Advance the model by one clock edge given the inputs presented before it.
  task automatic model_step(input bit valid, input int op, input int d, input int s,
                            input int unsigned imm, input bit sext);
    int unsigned old_d;
    m_done = 0;
    m_err  = 0;
    if (m_busy) begin
      m_r[m_psrc] = m_pval;
      m_busy      = 0;
      m_done      = 1;
    end else if (valid) begin
      m_done = 1;
      case (op)
        OP_MOV:  m_r[d] = m_r[s];
        OP_MOVI: m_r[d] = ext_imm(imm, sext);
        OP_CLR:  m_r[d] = 0;
        default: begin
`ifdef MOV_SWAP_EN
          old_d  = m_r[d];
          m_r[d] = m_r[s];
          m_psrc = s;
          m_pval = old_d;
          m_busy = 1;
          m_done = 0;
`else
          old_d = 0;
          m_err = 1;
`endif
        end
      endcase
    end
  endtask

  task automatic check_outputs();
    check_val("op_ready", bus.op_ready, 32'(!m_busy));
    check_val("done", bus.done, 32'(m_done));
    check_val("err", bus.err, 32'(m_err));
    for (int a = 0; a < int'(DEPTH); a++) begin
      bus.rd_addr = AW'(a);
      #1;
      check_val($sformatf("rd_data[%0d]", a), bus.rd_data, m_r[a]);
    end
  endtask

  task automatic drive(input bit valid, input int op, input int d, input int s,
                       input int unsigned imm, input bit sext);
    bus.op_valid = valid;
    bus.op_code  = 2'(op);
    bus.dst      = AW'(d);
    bus.src      = AW'(s);
    bus.imm      = IMM_W'(imm);
    bus.imm_sext = sext;
    model_step(valid, op, d, s, imm, sext);
  endtask

  // One clock: check outputs at the falling edge, then present the next inputs.
  task automatic cycle(input bit valid, input int op, input int d, input int s,
                       input int unsigned imm, input bit sext);
    @(negedge clk);
    check_outputs();
    drive(valid, op, d, s, imm, sext);
  endtask

  // Idle clock that also checks a register and the done/err flags against constants.
  task automatic peek(input string tag, input int addr, input logic [31:0] exp_val,
                      input bit exp_done, input bit exp_err);
    @(negedge clk);
    check_val({tag, "_done"}, bus.done, 32'(exp_done));
    check_val({tag, "_err"}, bus.err, 32'(exp_err));
    bus.rd_addr = AW'(addr);
    #1;
    check_val(tag, bus.rd_data, exp_val);
    check_outputs();
    drive(1'b0, OP_MOV, 0, 0, 0, 1'b0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_code  = '0;
    bus.dst      = '0;
    bus.src      = '0;
    bus.imm      = '0;
    bus.imm_sext = 1'b0;
    bus.rd_addr  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    peek("reset_r0", 0, 32'h0, 1'b0, 1'b0);

    // MOVI sign / zero extension
    cycle(1'b1, OP_MOVI, 2, 0, 4'hA, 1'b1);
    peek("movi_sext", 2, 32'hFA, 1'b1, 1'b0);
    cycle(1'b1, OP_MOVI, 2, 0, 4'hA, 1'b0);
    peek("movi_zext", 2, 32'h0A, 1'b1, 1'b0);

    // Back-to-back MOVI then MOV
    cycle(1'b1, OP_MOVI, 1, 0, 4'h5, 1'b0);
    cycle(1'b1, OP_MOV, 3, 1, 0, 1'b0);
    peek("mov_r3", 3, 32'h05, 1'b1, 1'b0);
    peek("mov_r1_kept", 1, 32'h05, 1'b0, 1'b0);

    // Swap with a following CLR held valid
    cycle(1'b1, OP_MOVI, 0, 0, 4'h3, 1'b0);
    cycle(1'b1, OP_MOVI, 1, 0, 4'hC, 1'b0);
    cycle(1'b1, OP_SWAP, 0, 1, 0, 1'b0);
    cycle(1'b1, OP_CLR, 2, 0, 0, 1'b0);
    cycle(1'b1, OP_CLR, 2, 0, 0, 1'b0);
`ifdef MOV_SWAP_EN
    peek("swap_r0", 0, 32'h0C, 1'b1, 1'b0);
    peek("swap_r1", 1, 32'h03, 1'b0, 1'b0);
`else
    peek("nop_r0", 0, 32'h03, 1'b1, 1'b0);
    peek("nop_r1", 1, 32'h0C, 1'b0, 1'b0);
`endif
    peek("clr_r2", 2, 32'h00, 1'b0, 1'b0);

    // Self-swap leaves the value, or NOP with err when swap is not built
    cycle(1'b1, OP_MOVI, 2, 0, 4'h7, 1'b0);
    cycle(1'b1, OP_SWAP, 2, 2, 0, 1'b0);
`ifdef MOV_SWAP_EN
    cycle(1'b0, OP_MOV, 0, 0, 0, 1'b0);
    peek("swap_self", 2, 32'h07, 1'b1, 1'b0);
`else
    peek("nop_self", 2, 32'h07, 1'b1, 1'b1);
    peek("nop_pulse_end", 2, 32'h07, 1'b0, 1'b0);
`endif

    // Reset during the cycle after a swap accept
    cycle(1'b1, OP_SWAP, 0, 1, 0, 1'b0);
    @(negedge clk);
    bus.op_valid = 1'b0;
    rst_n        = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    peek("post_rst_r0", 0, 32'h0, 1'b0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 9) < 7), int'($urandom_range(0, 3)),
            int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
            $urandom_range(0, (1 << IMM_W) - 1), 1'($urandom_range(0, 1)));
    end
    repeat (3) cycle(1'b0, OP_MOV, 0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
